// File: rtl/lab2_stim_checker.sv
// lab2_stim_checker: sweeps x over every code, samples z after a settle window and checks it against EXPECT.
// Optional macro LAB2_STIM_SIGNATURE_EN adds an 8-bit MISR signature output over the sampled z values.
module lab2_stim_checker #(
  parameter int W = 3,
  parameter int SETTLE = 1,
  parameter logic [2**W-1:0] EXPECT = 8'h96
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic         z,
  output logic [W-1:0] x,
  output logic         x_drive,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [W:0]   err_cnt,
  output logic [W-1:0] first_err,
  output logic         first_err_vld
`ifdef LAB2_STIM_SIGNATURE_EN
  ,
  output logic [7:0]   signature
`endif
);
  localparam logic [1:0] IDLE = 2'd0, HOLD = 2'd1, SAMPLE = 2'd2, DONE = 2'd3;
  localparam logic [3:0] HOLD_INIT = 4'(SETTLE - 1);
  logic [1:0] state;
  logic [3:0] hold_cnt;
  logic accept, mismatch;
  assign accept = start & ((state == IDLE) | (state == DONE));
  assign mismatch = z != EXPECT[x];
  assign pass = done & (err_cnt == '0);
  // Run sequencer: start a sweep, hold each code SETTLE cycles, then sample and advance
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      x <= '0;
      x_drive <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      err_cnt <= '0;
      first_err <= '0;
      first_err_vld <= 1'b0;
      hold_cnt <= '0;
    end else if (accept) begin
      state <= HOLD;
      x <= '0;
      x_drive <= 1'b1;
      busy <= 1'b1;
      done <= 1'b0;
      err_cnt <= '0;
      first_err <= '0;
      first_err_vld <= 1'b0;
      hold_cnt <= HOLD_INIT;
    end else if (state == HOLD) begin
      if (hold_cnt == '0) state <= SAMPLE;
      else hold_cnt <= hold_cnt - 1'b1;
    end else if (state == SAMPLE) begin
      if (mismatch) begin
        err_cnt <= err_cnt + 1'b1;
        if (!first_err_vld) begin
          first_err <= x;
          first_err_vld <= 1'b1;
        end
      end
      if (&x) begin
        state <= DONE;
        x <= '0;
        x_drive <= 1'b0;
        busy <= 1'b0;
        done <= 1'b1;
      end else begin
        x <= x + 1'b1;
        hold_cnt <= HOLD_INIT;
        state <= HOLD;
      end
    end
  end
`ifdef LAB2_STIM_SIGNATURE_EN
  // MISR compaction of every sampled z, seeded to all-ones on each accepted start
  always_ff @(posedge clock or posedge reset) begin
    if (reset) signature <= 8'h00;
    else if (accept) signature <= 8'hFF;
    else if (state == SAMPLE) signature <= {signature[6:0], 1'b0} ^ (signature[7] ? 8'h1D : 8'h00) ^ {7'b0, z};
  end
`endif
endmodule

// File: tb/tb_lab2_stim_checker.sv
// tb_lab2_stim_checker: randomized self-check of lab2_stim_checker against a table-level reference model.
module tb_lab2_stim_checker;
  logic clock = 1'b0;
  logic reset, start, start3, z, z3;
  logic [2:0] x, x3, fe, fe3;
  logic xd, xd3, busy, busy3, done, done3, pass, pass3, fev, fev3;
  logic [3:0] ec, ec3;
  logic [7:0] ztab;
  logic [2:0] xh1 = '0, xh2 = '0;
  int checks = 0, passed = 0;
`ifdef LAB2_STIM_SIGNATURE_EN
  logic [7:0] sig, sig3;
`endif

  always #5 clock = ~clock;

  assign z = ztab[x];
  // Second DUT sees parity of x delayed by two cycles
  always @(posedge clock) begin
    xh1 <= x3;
    xh2 <= xh1;
  end
  assign z3 = ^xh2;

  lab2_stim_checker dut (
    .clock(clock), .reset(reset), .start(start), .z(z), .x(x), .x_drive(xd), .busy(busy),
    .done(done), .pass(pass), .err_cnt(ec), .first_err(fe), .first_err_vld(fev)
`ifdef LAB2_STIM_SIGNATURE_EN
    , .signature(sig)
`endif
  );

  lab2_stim_checker #(.SETTLE(3)) dut3 (
    .clock(clock), .reset(reset), .start(start3), .z(z3), .x(x3), .x_drive(xd3), .busy(busy3),
    .done(done3), .pass(pass3), .err_cnt(ec3), .first_err(fe3), .first_err_vld(fev3)
`ifdef LAB2_STIM_SIGNATURE_EN
    , .signature(sig3)
`endif
  );

  function automatic logic [7:0] par_tab();
    logic [7:0] t;
    logic [2:0] cc;
    for (int c = 0; c < 8; c++) begin
      cc = 3'(c);
      t[c] = ^cc;
    end
    return t;
  endfunction

  function automatic logic [7:0] misr(input logic [7:0] tab);
    logic [7:0] s = 8'hFF;
    for (int c = 0; c < 8; c++) s = {s[6:0], 1'b0} ^ (s[7] ? 8'h1D : 8'h00) ^ {7'b0, tab[c]};
    return s;
  endfunction

  // Follows one run of dut from just after its accepted start edge to the done cycle
  task automatic track_a(input logic [7:0] tab, input string nm);
    int errs = 0, bad = -1;
    logic [2:0] efe = '0;
    logic efv = 1'b0;
    logic [7:0] exp_tab = par_tab();
    for (int c = 0; c < 8; c++)
      if (tab[c] != exp_tab[c]) begin
        errs++;
        if (!efv) begin
          efe = 3'(c);
          efv = 1'b1;
        end
      end
    for (int j = 0; j < 16; j++) begin
      @(negedge clock);
      if (bad < 0 && (x !== 3'(j / 2) || xd !== 1'b1 || busy !== 1'b1 || done !== 1'b0 ||
                      (j == 0 && (ec !== 4'd0 || fev !== 1'b0)))) bad = j;
    end
    checks++;
    if (bad >= 0) $display("FAIL %s seq: cycle %0d got x=%0d x_drive=%b busy=%b done=%b, want x=%0d x_drive=1 busy=1 done=0",
                           nm, bad, x, xd, busy, done, bad / 2);
    else passed++;
    @(negedge clock);
    checks++;
    if ({done, busy, xd, x, ec, fev, pass} !== {1'b1, 1'b0, 1'b0, 3'd0, 4'(errs), efv, 1'(errs == 0)} || (efv && fe !== efe))
      $display("FAIL %s result: got done=%b busy=%b xd=%b x=%0d err=%0d fev=%b fe=%0d pass=%b, want done=1 busy=0 xd=0 x=0 err=%0d fev=%b fe=%0d pass=%b",
               nm, done, busy, xd, x, ec, fev, fe, pass, errs, efv, efe, errs == 0);
    else passed++;
`ifdef LAB2_STIM_SIGNATURE_EN
    checks++;
    if (sig !== misr(tab)) $display("FAIL %s signature: got %h want %h", nm, sig, misr(tab));
    else passed++;
`endif
  endtask

  task automatic run_a(input logic [7:0] tab, input string nm);
    @(negedge clock);
    ztab = tab;
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    track_a(tab, nm);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    start3 = 1'b0;
    ztab = par_tab();
    repeat (2) @(negedge clock);
    checks++;
    if ({x, xd, busy, done, pass, ec, fe, fev} !== '0) $display("FAIL reset_a: got %b want all 0", {x, xd, busy, done, pass, ec, fe, fev});
    else passed++;
    checks++;
    if ({x3, xd3, busy3, done3, pass3, ec3, fe3, fev3} !== '0) $display("FAIL reset_b: got %b want all 0", {x3, xd3, busy3, done3, pass3, ec3, fe3, fev3});
    else passed++;
`ifdef LAB2_STIM_SIGNATURE_EN
    checks++;
    if (sig !== 8'h00) $display("FAIL reset_sig: got %h want 00", sig);
    else passed++;
`endif
    reset = 1'b0;
  endtask

  task automatic test_settle3();
    int bad = -1;
    @(negedge clock);
    start3 = 1'b1;
    @(posedge clock);
    #1 start3 = 1'b0;
    for (int j = 0; j < 32; j++) begin
      @(negedge clock);
      if (bad < 0 && (x3 !== 3'(j / 4) || busy3 !== 1'b1 || done3 !== 1'b0)) bad = j;
    end
    checks++;
    if (bad >= 0) $display("FAIL settle3 seq: cycle %0d got x=%0d busy=%b done=%b, want x=%0d busy=1 done=0", bad, x3, busy3, done3, bad / 4);
    else passed++;
    @(negedge clock);
    checks++;
    if ({done3, busy3, xd3, pass3, ec3, fev3} !== {1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0})
      $display("FAIL settle3 result: got done=%b busy=%b xd=%b pass=%b err=%0d fev=%b, want 1 0 0 1 0 0", done3, busy3, xd3, pass3, ec3, fev3);
    else passed++;
`ifdef LAB2_STIM_SIGNATURE_EN
    checks++;
    if (sig3 !== misr(par_tab())) $display("FAIL settle3 signature: got %h want %h", sig3, misr(par_tab()));
    else passed++;
`endif
  endtask

  task automatic test_random();
    logic [7:0] t;
    for (int i = 0; i < 6; i++) begin
      t = 8'($urandom);
      run_a(t, $sformatf("rand%0d", i));
    end
  endtask

  task automatic test_mid_reset();
    @(negedge clock);
    ztab = par_tab();
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    for (int i = 0; i < 20 && x !== 3'd5; i++) @(negedge clock);
    checks++;
    if (x !== 3'd5) $display("FAIL mid_reset wait: got x=%0d want 5", x);
    else passed++;
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({x, xd, busy, done, pass, ec, fe, fev} !== '0) $display("FAIL mid_reset clear: got %b want all 0", {x, xd, busy, done, pass, ec, fe, fev});
    else passed++;
    @(negedge clock);
    reset = 1'b0;
    run_a(par_tab(), "after_reset");
  endtask

  task automatic test_back_to_back();
    @(negedge clock);
    ztab = 8'h00;
    start = 1'b1;
    @(posedge clock);
    track_a(8'h00, "b2b_run1");
    ztab = par_tab();
    @(posedge clock);
    track_a(par_tab(), "b2b_run2");
    repeat (5) @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 40 && !(done === 1'b1); i++) @(negedge clock);
    checks++;
    if ({done, pass, ec} !== {1'b1, 1'b1, 4'd0}) $display("FAIL b2b_run3: got done=%b pass=%b err=%0d want 1 1 0", done, pass, ec);
    else passed++;
  endtask

`ifdef LAB2_STIM_SIGNATURE_EN
  task automatic test_signature();
    logic [7:0] s1, s2, s3, s4;
    run_a(par_tab(), "sig_par1");
    s1 = sig;
    run_a(par_tab(), "sig_par2");
    s2 = sig;
    run_a(8'h00, "sig_zero1");
    s3 = sig;
    run_a(8'h00, "sig_zero2");
    s4 = sig;
    checks++;
    if (s1 !== s2 || s3 !== s4) $display("FAIL sig_repeat: got %h/%h and %h/%h want equal pairs", s1, s2, s3, s4);
    else passed++;
    checks++;
    if (s1 === s3) $display("FAIL sig_distinct: got %h for both, want different", s1);
    else passed++;
  endtask
`endif

  initial begin
    test_reset();
    run_a(par_tab(), "parity");
    run_a(8'h00, "stuck0");
    test_settle3();
    test_random();
    test_mid_reset();
    test_back_to_back();
`ifdef LAB2_STIM_SIGNATURE_EN
    test_signature();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
